instruction_encode: RTL
=======================

# instruction_encode

- Inverse of the instruction-decode stage: turns a mnemonic back into a 32-bit RV32I instruction word.
- Receives the mnemonic as an ASCII character stream, which a UART front end or debug console typically supplies.
- Samples the operand fields, builds the RV32I word and presents it on a valid/ready output handshake.
- Used for loading test programs into instruction memory and for round-trip checking of the decode stage; covers the same 37-mnemonic set the decoder recognises.

## Interface

Parameters:
- MNEM_LEN, 5: maximum mnemonic length in characters; the buffer is 8*MNEM_LEN bits, space-padded on the right.
- TERM_CHAR, 8'h0D: character that ends a mnemonic.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- char_in  in  8  ASCII mnemonic character.
- char_valid  in  1  char_in is valid.
- char_ready  out  1  block accepts a character; equals (state == COLLECT).
- rd  in  5  destination register, sampled with the terminator.
- rs1  in  5  source register 1, sampled with the terminator.
- rs2  in  5  source register 2, sampled with the terminator.
- imm  in  32  immediate, sampled with the terminator.
- instr_out  out  32  encoded instruction.
- instr_valid  out  1  instr_out/error valid.
- instr_ready  in  1  consumer accepts instr_out.
- error  out  1  current instr_out is a substituted NOP, not a requested encoding.

Reset: one clock; reset is asynchronous and active-low.

## Operation

- The state machine has three states: COLLECT, ENCODE and HOLD.
- **COLLECT:**
  - A character is accepted on `char_valid && char_ready`.
  - Characters a–z are converted to A–Z.
  - A non-terminator with count < MNEM_LEN is written to buffer byte [39-8*count -: 8], then count increments.
  - A non-terminator with count == MNEM_LEN sets an overflow flag; the buffer is left unchanged.
  - A terminator latches rd/rs1/rs2/imm and moves to ENCODE.
- **ENCODE** (one cycle):
  - The space-padded buffer is compared against the mnemonic list, and instr_out, error and instr_valid=1 are registered.
  - The state moves to HOLD.
- **HOLD:**
  - Outputs are held stable until `instr_valid && instr_ready`.
  - On that edge: instr_valid=0, buffer reset to spaces, count=0, overflow cleared, state returns to COLLECT.
  - error and instr_out keep their last value.
- **Error cases:** unknown mnemonic, empty mnemonic (count==0 at terminator), or overflow. Each produces instr_out=32'h00000013 with error=1.
- **Encodings.** Fields not listed below are zero.
  - R-type, opcode 0110011: ADD/SUB f3=0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL/SRA 5, OR 6, AND 7.
    - funct7 is 0x20 for SUB and SRA, 0x00 otherwise.
    - Word = {funct7, rs2, rs1, f3, rd, op}.
  - I-ALU, opcode 0010011: ADDI 0, SLTI 2, SLTIU 3, XORI 4, ORI 6, ANDI 7.
    - Word = {imm[11:0], rs1, f3, rd, op}.
  - Shift immediates: SLLI f3=1, SRLI 5, SRAI 5.
    - Bits [31:25] = 0x00, except 0x20 for SRAI; bits [24:20] = imm[4:0].
  - Loads, opcode 0000011: LB 0, LH 1, LW 2, LBU 4, LHU 5. JALR uses opcode 1100111, f3=0. Both use I layout.
  - Stores, opcode 0100011: SB 0, SH 1, SW 2.
    - Word = {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - Branches, opcode 1100011: BEQ 0, BNE 1, BLT 4, BGE 5, BLTU 6, BGEU 7.
    - Word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; imm[0] is ignored.
  - LUI (0110111) and AUIPC (0010111): word = {imm[31:12], rd, op}.
  - JAL (1101111): word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Out-of-range immediate bits are silently truncated; they do not raise error.

## Timing

- **Reset values:** state=COLLECT, char_ready=1, instr_valid=0, instr_out=0, error=0, count=0, buffer all spaces, overflow=0.
- **Latency:** terminator accepted at edge E; instr_valid is high after edge E+1.
- Earliest next character acceptance is at the edge following the output handshake edge.
- char_ready is 0 throughout ENCODE and HOLD; char_valid is ignored there.
- If instr_ready is already high when instr_valid rises, the transfer completes at the next edge (edge E+2).
- Operand inputs are don't-care except on the terminator edge.
- Reset asserted mid-collection or during HOLD immediately returns all reset values; any pending instruction is discarded.

## Test plan

- **ADD:** "ADD\r", rd=1, rs1=2, rs2=3 → instr_out=0x003100B3, error=0, instr_valid high one edge after the terminator edge.
- **ADDI, lowercase:** "addi\r", rd=5, rs1=0, imm=0xFFFFFFFF → 0xFFF00293.
- **SW:** "SW\r", rs1=2, rs2=10, imm=8 → 0x00A12423.
- **BEQ:** "BEQ\r", rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3.
- **JAL:** "JAL\r", rd=1, imm=0x800 → 0x001000EF.
- **SRAI:** rd=3, rs1=3, imm=4 → 0x4041D193.
- **Errors:**
  - "FOO\r" → 0x00000013, error=1.
  - "ADDIXY\r" (overflow) → 0x00000013, error=1.
  - "\r" alone (empty) → 0x00000013, error=1.
- **Backpressure and reset:**
  - Hold instr_ready=0 for 3 cycles → instr_out and instr_valid stable and char_ready=0 throughout.
  - Assert reset_n=0 after "AD" → all reset values; a following "OR\r" with rd=4, rs1=5, rs2=6 → 0x0062E233.

Source files
------------

// File: rtl/instruction_encode_if.sv
// Handshake bundle for instruction_encode: character stream in, operand
// fields, and the encoded-instruction valid/ready output.
interface instruction_encode_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        error;

    // Producer of characters/operands and consumer of instructions
    modport master (
        output char_in, char_valid, rd, rs1, rs2, imm, instr_ready,
        input  char_ready, instr_out, instr_valid, error
    );

    // The encoder itself
    modport slave (
        input  char_in, char_valid, rd, rs1, rs2, imm, instr_ready,
        output char_ready, instr_out, instr_valid, error
    );
endinterface

// File: rtl/instruction_encode.sv
// instruction_encode: collects an ASCII mnemonic, samples operand fields on
// the terminator and emits the matching RV32I instruction word over a
// valid/ready handshake. Unknown, empty or over-long mnemonics yield a NOP
// with error set.
module instruction_encode #(
    parameter int          MNEM_LEN  = 5,
    parameter logic [7:0]  TERM_CHAR = 8'h0D
) (
    input  logic                 clock,
    input  logic                 reset_n,
    instruction_encode_if.slave  bus
);

    localparam int                BUF_W  = 8 * MNEM_LEN;
    localparam int                CNT_W  = $clog2(MNEM_LEN + 1);
    localparam logic [BUF_W-1:0]  SPACES = {MNEM_LEN{8'h20}};
    localparam logic [31:0]       NOP    = 32'h0000_0013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {COLLECT, ENCODE, HOLD} state_t;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [BUF_W-1:0]   buf_q;
    logic               ovf_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [31:0]        imm_q;
    logic [31:0]        instr_out_q;
    logic               error_q;
    logic               valid_q;

    logic [7:0]         char_up_d;
    logic               accept_d;
    logic [39:0]        key_d;
    logic               extra_d;
    fmt_t               fmt_d;
    logic [6:0]         op_d;
    logic [2:0]         f3_d;
    logic [6:0]         f7_d;
    logic               known_d;
    logic [31:0]        word_d;
    logic               err_d;
    logic [31:0]        instr_d;

    // Longest mnemonic is 5 characters; the buffer is reduced to a 5-byte
    // key and any non-space beyond it marks the mnemonic as unknown.
    function automatic logic [40:0] key_of(input logic [BUF_W-1:0] b);
        logic [39:0] k;
        logic        extra;
        k     = {5{8'h20}};
        extra = 1'b0;
        for (int i = 0; i < MNEM_LEN; i++) begin
            if (i < 5) k[39-8*i -: 8] = b[BUF_W-1-8*i -: 8];
            else if (b[BUF_W-1-8*i -: 8] != 8'h20) extra = 1'b1;
        end
        return {extra, k};
    endfunction

    assign accept_d  = bus.char_valid && (state_q == COLLECT);
    assign char_up_d = (bus.char_in >= 8'h61 && bus.char_in <= 8'h7A) ?
                       (bus.char_in - 8'h20) : bus.char_in;
    assign {extra_d, key_d} = key_of(buf_q);

    // Mnemonic lookup: format, opcode and function fields
    always_comb begin
        fmt_d   = FMT_R;
        op_d    = 7'd0;
        f3_d    = 3'd0;
        f7_d    = 7'd0;
        known_d = 1'b1;
        case (key_d)
            "ADD  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd0; end
            "SUB  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd0; f7_d = 7'h20; end
            "SLL  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd1; end
            "SLT  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd2; end
            "SLTU ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd3; end
            "XOR  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd4; end
            "SRL  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd5; end
            "SRA  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd5; f7_d = 7'h20; end
            "OR   ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd6; end
            "AND  ": begin fmt_d = FMT_R;  op_d = OP_R;     f3_d = 3'd7; end
            "ADDI ": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd0; end
            "SLTI ": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd2; end
            "SLTIU": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd3; end
            "XORI ": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd4; end
            "ORI  ": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd6; end
            "ANDI ": begin fmt_d = FMT_I;  op_d = OP_I;     f3_d = 3'd7; end
            "SLLI ": begin fmt_d = FMT_SH; op_d = OP_I;     f3_d = 3'd1; end
            "SRLI ": begin fmt_d = FMT_SH; op_d = OP_I;     f3_d = 3'd5; end
            "SRAI ": begin fmt_d = FMT_SH; op_d = OP_I;     f3_d = 3'd5; f7_d = 7'h20; end
            "LB   ": begin fmt_d = FMT_I;  op_d = OP_LOAD;  f3_d = 3'd0; end
            "LH   ": begin fmt_d = FMT_I;  op_d = OP_LOAD;  f3_d = 3'd1; end
            "LW   ": begin fmt_d = FMT_I;  op_d = OP_LOAD;  f3_d = 3'd2; end
            "LBU  ": begin fmt_d = FMT_I;  op_d = OP_LOAD;  f3_d = 3'd4; end
            "LHU  ": begin fmt_d = FMT_I;  op_d = OP_LOAD;  f3_d = 3'd5; end
            "JALR ": begin fmt_d = FMT_I;  op_d = OP_JALR;  f3_d = 3'd0; end
            "SB   ": begin fmt_d = FMT_S;  op_d = OP_STORE; f3_d = 3'd0; end
            "SH   ": begin fmt_d = FMT_S;  op_d = OP_STORE; f3_d = 3'd1; end
            "SW   ": begin fmt_d = FMT_S;  op_d = OP_STORE; f3_d = 3'd2; end
            "BEQ  ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd0; end
            "BNE  ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd1; end
            "BLT  ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd4; end
            "BGE  ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd5; end
            "BLTU ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd6; end
            "BGEU ": begin fmt_d = FMT_B;  op_d = OP_BR;    f3_d = 3'd7; end
            "LUI  ": begin fmt_d = FMT_U;  op_d = OP_LUI;   end
            "AUIPC": begin fmt_d = FMT_U;  op_d = OP_AUIPC; end
            "JAL  ": begin fmt_d = FMT_J;  op_d = OP_JAL;   end
            default: known_d = 1'b0;
        endcase
    end

    // Field assembly for the selected format, NOP substitution on error
    always_comb begin
        word_d = NOP;
        case (fmt_d)
            FMT_R:   word_d = {f7_d, rs2_q, rs1_q, f3_d, rd_q, op_d};
            FMT_I:   word_d = {imm_q[11:0], rs1_q, f3_d, rd_q, op_d};
            FMT_SH:  word_d = {f7_d, imm_q[4:0], rs1_q, f3_d, rd_q, op_d};
            FMT_S:   word_d = {imm_q[11:5], rs2_q, rs1_q, f3_d, imm_q[4:0], op_d};
            FMT_B:   word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_d,
                               imm_q[4:1], imm_q[11], op_d};
            FMT_U:   word_d = {imm_q[31:12], rd_q, op_d};
            FMT_J:   word_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                               rd_q, op_d};
            default: word_d = NOP;
        endcase
        err_d   = !known_d || ovf_q || extra_d || (count_q == '0);
        instr_d = err_d ? NOP : word_d;
    end

    // Operand capture on the terminator; these are pure data and need no reset
    always_ff @(posedge clock) begin
        if (accept_d && bus.char_in == TERM_CHAR) begin
            rd_q  <= bus.rd;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            imm_q <= bus.imm;
        end
    end

    // Control FSM: collect characters, encode for one cycle, hold for handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            count_q     <= '0;
            buf_q       <= SPACES;
            ovf_q       <= 1'b0;
            instr_out_q <= '0;
            error_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept_d) begin
                        if (bus.char_in == TERM_CHAR) begin
                            state_q <= ENCODE;
                        end else if (int'(count_q) < MNEM_LEN) begin
                            buf_q[BUF_W-1-8*int'(count_q) -: 8] <= char_up_d;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                ENCODE: begin
                    instr_out_q <= instr_d;
                    error_q     <= err_d;
                    valid_q     <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        buf_q   <= SPACES;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.char_ready  = (state_q == COLLECT);
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = valid_q;
    assign bus.error       = error_q;

endmodule
